// File: rtl/spi_rx_fifo_if.sv
// spi_rx_fifo_if -- pin/handshake bundle for the spi_rx_fifo receiver.
//   spi_clk, spi_mosi, spi_cs : asynchronous SPI pins (spi_cs active-low)
//   mode                      : {CPOL,CPHA}, latched by the receiver at frame start
//   out_data, out_first       : FIFO head word and its first-word-of-frame flag
//   out_valid / out_ready     : first-word-fall-through pop handshake
//   level, overflow, busy     : words held, dropped-word pulse, frame in progress
// master = the side driving the SPI pins and out_ready; slave = the receiver.
interface spi_rx_fifo_if #(
  parameter int WORD_BITS  = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 spi_clk;
  logic                 spi_mosi;
  logic                 spi_cs;
  logic [1:0]           mode;
  logic [WORD_BITS-1:0] out_data;
  logic                 out_first;
  logic                 out_valid;
  logic                 out_ready;
  logic [LVL_W-1:0]     level;
  logic                 overflow;
  logic                 busy;

  modport master (
    output spi_clk, spi_mosi, spi_cs, mode, out_ready,
    input  out_data, out_first, out_valid, level, overflow, busy
  );

  modport slave (
    input  spi_clk, spi_mosi, spi_cs, mode, out_ready,
    output out_data, out_first, out_valid, level, overflow, busy
  );
endinterface

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo -- SPI slave receiver feeding a first-word-fall-through FIFO.
// The SPI pins are oversampled in the clk domain (spi_clk <= clk/4). Each
// completed WORD_BITS word is pushed with a flag marking the first word of a
// spi_cs frame. A partial word is discarded when spi_cs rises.
// Ports:
//   clk    : system clock, the only clock
//   resetn : asynchronous active-low reset
//   bus    : spi_rx_fifo_if.slave (SPI pins, mode, pop handshake, status)
// Optional feature: define SPI_RX_FIFO_TIMEOUT_EN to abort a partial word
// after TIMEOUT_CYCLES clk cycles without a sample edge (frame stays open).
module spi_rx_fifo #(
  parameter int WORD_BITS      = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter bit LSBFIRST       = 1'b0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          resetn,
  spi_rx_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PUSH  = 2'd2;

  // ---------------- pin synchronizers ----------------
  logic [1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic       sclk_prev_q, cs_prev_q;
  logic [1:0] sync_ok_q;   // fills with 1s once the sync chains hold real pin samples
  logic       cs_armed_q;  // spi_cs has been seen high since reset

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two-flop synchronizer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      sync_ok_q   <= 2'b00;
      cs_armed_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], bus.spi_clk};
      mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
      cs_sync_q   <= {cs_sync_q[0], bus.spi_cs};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
      sync_ok_q   <= {sync_ok_q[0], 1'b1};
      if (sync_ok_q[1] && cs_sync_q[1]) cs_armed_q <= 1'b1;
    end
  end

  logic sclk_s, mosi_s, cs_s;
  assign sclk_s = sclk_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
  assign cs_s   = cs_sync_q[1];

  // The reset value of the cs chain (high) would otherwise look like a falling
  // edge if spi_cs is held low through reset; a frame only starts after cs was high.
  logic cs_fall;
  assign cs_fall = cs_armed_q & cs_prev_q & ~cs_s;

  // ---------------- receive FSM ----------------
  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic                 first_q, first_d;
  logic [1:0]           mode_q, mode_d;
  logic                 push;
  logic                 sample_edge;
  logic                 timeout_hit;

  // Sample on the leading edge (CPHA=0) or trailing edge (CPHA=1). The edge
  // is leading when spi_clk moves to !CPOL, so the sample level is !(CPOL^CPHA).
  assign sample_edge = (sclk_s != sclk_prev_q) && (sclk_s == ~(mode_q[1] ^ mode_q[0]));

`ifdef SPI_RX_FIFO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_inc;
  logic            to_run;

  // Idle time is counted only while a partial word is held in an open frame.
  assign to_run      = (state_q == ST_SHIFT) && !cs_s && (cnt_q != '0) && !sample_edge;
  assign to_inc      = to_cnt_q + 1'b1;
  assign timeout_hit = to_run && (to_inc == TO_W'(TIMEOUT_CYCLES));
  assign to_cnt_d    = (to_run && !timeout_hit) ? to_inc : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    first_d = first_q;
    mode_d  = mode_q;
    push    = 1'b0;
    if (cs_fall) begin
      first_d = 1'b1;
      mode_d  = bus.mode;
    end
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_s) begin
          state_d = ST_IDLE;          // frame ended: partial word is dropped
          cnt_d   = '0;
        end else if (sample_edge) begin
          shreg_d = LSBFIRST ? {mosi_s, shreg_q[WORD_BITS-1:1]}
                             : {shreg_q[WORD_BITS-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) state_d = ST_PUSH;
        end else if (timeout_hit) begin
          cnt_d = '0;
        end
      end
      ST_PUSH: begin
        push    = 1'b1;
        first_d = 1'b0;
        cnt_d   = '0;
        state_d = cs_s ? ST_IDLE : ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      first_q <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      first_q <= first_d;
      mode_q  <= mode_d;
    end
  end

  // ---------------- FIFO ----------------
  logic [WORD_BITS:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               overflow_q;
  logic               out_valid, pop, full, wr_en, drop;
  logic [WORD_BITS:0] head;

  assign out_valid = (level_q != '0);
  assign pop       = out_valid & bus.out_ready;
  assign full      = (level_q == FULL_LVL);
  assign wr_en     = push & (~full | pop);   // a same-cycle pop frees the slot
  assign drop      = push & full & ~pop;

  // NOTE: the storage array is not reset; only pointers and level are, and the
  // outputs are gated by out_valid so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {shreg_q, first_q};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= drop;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !wr_en) level_q <= level_q - 1'b1;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.out_data  = out_valid ? head[WORD_BITS:1] : '0;
  assign bus.out_first = out_valid & head[0];
  assign bus.out_valid = out_valid;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = ~cs_s;
endmodule

// File: tb/tb_spi_rx_fifo.sv
// Directed bench for spi_rx_fifo. Two receivers share the same SPI pins and
// pop handshake: dut_m shifts MSB first, dut_l shifts LSB first.
module tb_spi_rx_fifo;
  localparam int W = 32;
  localparam int D = 4;
  localparam int H = 4;   // clk cycles per spi_clk half period

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, cs = 1'b1, rdy = 1'b0;
  logic [1:0] mode = 2'b00;
  int         errors = 0;
  int         checks = 0;
  int         ovf_m = 0;   // cycles with overflow high on dut_m

  always #5 clk = ~clk;

  spi_rx_fifo_if #(.WORD_BITS(W), .FIFO_DEPTH(D)) bus_m ();
  spi_rx_fifo_if #(.WORD_BITS(W), .FIFO_DEPTH(D)) bus_l ();

  assign bus_m.spi_clk = sclk;  assign bus_l.spi_clk = sclk;
  assign bus_m.spi_mosi = mosi; assign bus_l.spi_mosi = mosi;
  assign bus_m.spi_cs = cs;     assign bus_l.spi_cs = cs;
  assign bus_m.mode = mode;     assign bus_l.mode = mode;
  assign bus_m.out_ready = rdy; assign bus_l.out_ready = rdy;

  spi_rx_fifo #(.WORD_BITS(W), .FIFO_DEPTH(D), .LSBFIRST(1'b0), .TIMEOUT_CYCLES(64))
    dut_m (.clk(clk), .resetn(resetn), .bus(bus_m));
  spi_rx_fifo #(.WORD_BITS(W), .FIFO_DEPTH(D), .LSBFIRST(1'b1), .TIMEOUT_CYCLES(64))
    dut_l (.clk(clk), .resetn(resetn), .bus(bus_l));

  always @(posedge clk) if (bus_m.overflow === 1'b1) ovf_m <= ovf_m + 1;

  task automatic wait_h();
    repeat (H) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; rdy = 1'b0; mode = 2'b00;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic frame_start(input logic [1:0] m);
    mode = m; sclk = m[1]; mosi = 1'b0;
    wait_h(); cs = 1'b0; wait_h();
  endtask

  task automatic frame_end();
    wait_h(); cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Transmit bits first..first+n-1 of w, in LSB-first or MSB-first order.
  task automatic send_bits(input logic [31:0] w, input int first, input int n, input bit lsb);
    logic b;
    for (int i = first; i < first + n; i++) begin
      b = lsb ? w[i] : w[31-i];
      if (!mode[0]) mosi = b;
      wait_h(); sclk = ~mode[1];
      if (mode[0]) mosi = b;
      wait_h(); sclk = mode[1];
    end
  endtask

  task automatic pop_one();
    rdy = 1'b1; @(negedge clk); rdy = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus_m.out_valid); end
    checks++; if (bus_m.level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", bus_m.level); end
    checks++; if (bus_m.out_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", bus_m.out_data); end
    checks++; if (bus_m.out_first !== 1'b0) begin errors++; $display("FAIL rst_first: got %b want 0", bus_m.out_first); end
    checks++; if (bus_m.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", bus_m.overflow); end
    checks++; if (bus_m.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus_m.busy); end
    // load one word with cs still low, then reset between clock edges
    frame_start(2'b00);
    send_bits(32'h0BADCAFE, 0, 32, 1'b0);
    repeat (8) @(negedge clk);
    checks++; if (bus_m.busy !== 1'b1) begin errors++; $display("FAIL pre_busy: got %b want 1", bus_m.busy); end
    checks++; if (bus_m.level !== 3'd1) begin errors++; $display("FAIL pre_level: got %0d want 1", bus_m.level); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (bus_m.level !== 3'd0) begin errors++; $display("FAIL arst_level: got %0d want 0", bus_m.level); end
    checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", bus_m.out_valid); end
    checks++; if (bus_m.out_data !== 32'h0) begin errors++; $display("FAIL arst_data: got %h want 0", bus_m.out_data); end
    checks++; if (bus_m.out_first !== 1'b0) begin errors++; $display("FAIL arst_first: got %b want 0", bus_m.out_first); end
    checks++; if (bus_m.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", bus_m.busy); end
    cs = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_midword();
    do_reset();
    frame_start(2'b00);
    send_bits(32'hFFFF0000, 0, 13, 1'b0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    // cs never went high again: this word must not be received
    send_bits(32'hCAFEF00D, 0, 32, 1'b0);
    repeat (8) @(negedge clk);
    checks++; if (bus_m.level !== 3'd0) begin errors++; $display("FAIL midrst_level: got %0d want 0", bus_m.level); end
    checks++; if (bus_m.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b want 1", bus_m.busy); end
    frame_end();
    frame_start(2'b00);
    send_bits(32'h0F0F0F0F, 0, 32, 1'b0);
    frame_end();
    checks++; if (bus_m.level !== 3'd1) begin errors++; $display("FAIL restart_level: got %0d want 1", bus_m.level); end
    checks++; if (bus_m.out_data !== 32'h0F0F0F0F) begin errors++; $display("FAIL restart_data: got %h want 0f0f0f0f", bus_m.out_data); end
    checks++; if (bus_m.out_first !== 1'b1) begin errors++; $display("FAIL restart_first: got %b want 1", bus_m.out_first); end
  endtask

  task automatic test_mode0();
    do_reset();
    frame_start(2'b00);
    send_bits(32'hDEADBEEF, 0, 32, 1'b0);
    frame_end();
    checks++; if (bus_m.out_valid !== 1'b1) begin errors++; $display("FAIL m0_valid: got %b want 1", bus_m.out_valid); end
    checks++; if (bus_m.out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL m0_data: got %h want deadbeef", bus_m.out_data); end
    checks++; if (bus_m.out_first !== 1'b1) begin errors++; $display("FAIL m0_first: got %b want 1", bus_m.out_first); end
    checks++; if (bus_m.level !== 3'd1) begin errors++; $display("FAIL m0_level: got %0d want 1", bus_m.level); end
  endtask

  task automatic test_mode3_lsb();
    do_reset();
    frame_start(2'b11);
    send_bits(32'h12345678, 0, 32, 1'b1);
    send_bits(32'h9ABCDEF0, 0, 32, 1'b1);
    frame_end();
    checks++; if (bus_l.level !== 3'd2) begin errors++; $display("FAIL m3_level: got %0d want 2", bus_l.level); end
    checks++; if (bus_l.out_data !== 32'h12345678) begin errors++; $display("FAIL m3_data0: got %h want 12345678", bus_l.out_data); end
    checks++; if (bus_l.out_first !== 1'b1) begin errors++; $display("FAIL m3_first0: got %b want 1", bus_l.out_first); end
    repeat (5) @(negedge clk);
    checks++; if (bus_l.out_data !== 32'h12345678) begin errors++; $display("FAIL m3_hold: got %h want 12345678", bus_l.out_data); end
    pop_one();
    checks++; if (bus_l.out_data !== 32'h9ABCDEF0) begin errors++; $display("FAIL m3_data1: got %h want 9abcdef0", bus_l.out_data); end
    checks++; if (bus_l.out_first !== 1'b0) begin errors++; $display("FAIL m3_first1: got %b want 0", bus_l.out_first); end
    checks++; if (bus_l.level !== 3'd1) begin errors++; $display("FAIL m3_level1: got %0d want 1", bus_l.level); end
    pop_one();
    checks++; if (bus_l.out_valid !== 1'b0) begin errors++; $display("FAIL m3_empty: got %b want 0", bus_l.out_valid); end
    checks++; if (bus_l.level !== 3'd0) begin errors++; $display("FAIL m3_level0: got %0d want 0", bus_l.level); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w [4];
    int base;
    exp_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_reset();
    base = ovf_m;
    frame_start(2'b00);
    for (int k = 0; k < 4; k++) send_bits(exp_w[k], 0, 32, 1'b0);
    repeat (8) @(negedge clk);
    checks++; if (bus_m.level !== 3'd4) begin errors++; $display("FAIL ovf_full_level: got %0d want 4", bus_m.level); end
    checks++; if (ovf_m - base !== 0) begin errors++; $display("FAIL ovf_early: got %0d pulses want 0", ovf_m - base); end
    send_bits(32'h55555555, 0, 32, 1'b0);
    repeat (8) @(negedge clk);
    checks++; if (bus_m.level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", bus_m.level); end
    checks++; if (ovf_m - base !== 1) begin errors++; $display("FAIL ovf_pulses: got %0d want 1", ovf_m - base); end
    frame_end();
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus_m.out_data !== exp_w[k]) begin errors++; $display("FAIL ovf_data%0d: got %h want %h", k, bus_m.out_data, exp_w[k]); end
      checks++; if (bus_m.out_first !== (k == 0)) begin errors++; $display("FAIL ovf_first%0d: got %b want %b", k, bus_m.out_first, (k == 0)); end
      pop_one();
    end
    checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b want 0", bus_m.out_valid); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_w [5];
    int base;
    exp_w = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4, 32'hE5E5E5E5};
    do_reset();
    frame_start(2'b00);
    for (int k = 0; k < 4; k++) send_bits(exp_w[k], 0, 32, 1'b0);
    repeat (8) @(negedge clk);
    checks++; if (bus_m.level !== 3'd4) begin errors++; $display("FAIL fp_full: got %0d want 4", bus_m.level); end
    base = ovf_m;
    send_bits(exp_w[4], 0, 31, 1'b0);
    // last bit by hand: the sample edge is seen 2 cycles after sclk rises and
    // the push happens on the 4th posedge, where out_ready must be high
    mosi = exp_w[4][0];
    wait_h(); sclk = 1'b1;
    repeat (3) @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0; sclk = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (bus_m.level !== 3'd4) begin errors++; $display("FAIL fp_level: got %0d want 4", bus_m.level); end
    checks++; if (ovf_m - base !== 0) begin errors++; $display("FAIL fp_ovf: got %0d pulses want 0", ovf_m - base); end
    frame_end();
    for (int k = 1; k < 5; k++) begin
      checks++; if (bus_m.out_data !== exp_w[k]) begin errors++; $display("FAIL fp_data%0d: got %h want %h", k, bus_m.out_data, exp_w[k]); end
      checks++; if (bus_m.out_first !== 1'b0) begin errors++; $display("FAIL fp_first%0d: got %b want 0", k, bus_m.out_first); end
      pop_one();
    end
    checks++; if (bus_m.level !== 3'd0) begin errors++; $display("FAIL fp_drained: got %0d want 0", bus_m.level); end
  endtask

  task automatic test_cs_abort();
    do_reset();
    frame_start(2'b00);
    send_bits(32'hFFFFFFFF, 0, 13, 1'b0);
    frame_end();
    checks++; if (bus_m.level !== 3'd0) begin errors++; $display("FAIL abort_level: got %0d want 0", bus_m.level); end
    frame_start(2'b00);
    send_bits(32'h00000001, 0, 32, 1'b0);
    frame_end();
    checks++; if (bus_m.level !== 3'd1) begin errors++; $display("FAIL abort_level1: got %0d want 1", bus_m.level); end
    checks++; if (bus_m.out_data !== 32'h00000001) begin errors++; $display("FAIL abort_data: got %h want 00000001", bus_m.out_data); end
    checks++; if (bus_m.out_first !== 1'b1) begin errors++; $display("FAIL abort_first: got %b want 1", bus_m.out_first); end
  endtask

  task automatic test_pause();
    do_reset();
    frame_start(2'b00);
    send_bits(32'hFF000000, 0, 8, 1'b0);
    repeat (100) @(negedge clk);
`ifdef SPI_RX_FIFO_TIMEOUT_EN
    send_bits(32'hA5A5A5A5, 0, 32, 1'b0);
    frame_end();
    checks++; if (bus_m.level !== 3'd1) begin errors++; $display("FAIL to_level: got %0d want 1", bus_m.level); end
    checks++; if (bus_m.out_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL to_data: got %h want a5a5a5a5", bus_m.out_data); end
`else
    send_bits(32'h00A5A5A5, 8, 24, 1'b0);
    frame_end();
    checks++; if (bus_m.level !== 3'd1) begin errors++; $display("FAIL keep_level: got %0d want 1", bus_m.level); end
    checks++; if (bus_m.out_data !== 32'hFFA5A5A5) begin errors++; $display("FAIL keep_data: got %h want ffa5a5a5", bus_m.out_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_midword();
    test_mode0();
    test_mode3_lsb();
    test_overflow();
    test_full_pop();
    test_cs_abort();
    test_pause();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_rx_fifo.md
SPI_RX_FIFO -- requirements
Module: spi_rx_fifo

Interface
REQ-001 SHALL have parameter WORD_BITS, default 32, meaning shift-word width (legal 8..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-word buffer depth (power of 2, 2..16).
REQ-003 SHALL have parameter LSBFIRST, default 0, meaning 1 shifts LSB first, 0 shifts MSB first.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning idle clk cycles before partial-word abort (used only with the timeout macro).
REQ-005 SHALL have clk, input, 1, system clock; the only clock.
REQ-006 SHALL have resetn, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have spi_clk, spi_mosi, spi_cs, input, 1 each, asynchronous SPI pins; spi_cs active-low.
REQ-008 SHALL have mode, input, 2, {CPOL,CPHA}; latched on spi_cs falling edge.
REQ-009 SHALL have out_data, output, WORD_BITS, FIFO head word.
REQ-010 SHALL have out_first, output, 1, head word was the first word after a spi_cs falling edge.
REQ-011 SHALL have out_valid (output, 1) and out_ready (input, 1), pop handshake.
REQ-012 SHALL have level, output, $clog2(FIFO_DEPTH)+1, words held.
REQ-013 SHALL have overflow, output, 1, one-cycle pulse when a completed word is dropped.
REQ-014 SHALL have busy, output, 1, high while spi_cs is synchronized low.

Function
REQ-015 SHALL pass spi_clk, spi_mosi, spi_cs through 2-flop synchronizers plus one previous-value flop for edge detection; spi_clk frequency is limited to clk/4.
REQ-016 SHALL define the sample edge as the idle-to-active transition (CPOL→!CPOL) when CPHA=0, and the active-to-idle transition when CPHA=1, using the latched mode.
REQ-017 SHALL implement states IDLE (cs high), SHIFT (cs low, bit counter 0..WORD_BITS-1), PUSH (one cycle).
REQ-018 SHALL, in SHIFT on each detected sample edge (cycle D), shift in synchronized mosi per LSBFIRST and increment the counter; on the WORD_BITS-th edge go to PUSH at D+1.
REQ-019 SHALL in PUSH write {word, first_flag} into the FIFO, clear first_flag, reset the counter, and return to SHIFT (IDLE if cs high); out_valid is high from D+2 when the FIFO was empty.
REQ-020 SHALL set first_flag on the synchronized spi_cs falling edge.
REQ-021 SHALL, on synchronized spi_cs rising mid-word, discard the partial word without push and enter IDLE.
REQ-022 SHALL be first-word-fall-through: out_valid = (level != 0); pop when out_valid && out_ready.
REQ-023 SHALL, on push while full, accept the word if a pop occurs in the same cycle, else drop it and pulse overflow; level unchanged either way.
REQ-024 SHALL, on push and pop in the same cycle, leave level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL hold out_data/out_first stable while out_valid && !out_ready.

Reset
REQ-026 SHALL, on resetn low, immediately clear state to IDLE, counter, pointers, level, first_flag, synchronizers (spi_cs syncs to 1, spi_clk syncs to 0), latched mode to 0; out_valid=0, out_data=0, out_first=0, overflow=0, busy=0.
REQ-027 SHALL, on reset mid-word, discard all partial and buffered data; reception restarts only after a new spi_cs falling edge.

Configuration
REQ-028 SHALL, when SPI_RX_FIFO_TIMEOUT_EN is defined, count clk cycles in SHIFT with counter != 0 since the last sample edge and, on reaching TIMEOUT_CYCLES, discard the partial word and reset the counter (remaining in SHIFT).
REQ-029 SHALL, when SPI_RX_FIFO_TIMEOUT_EN is undefined, omit the timeout counter entirely; partial words persist until spi_cs rises.

Verification
REQ-030 SHALL cover mode 0, WORD_BITS=32, MSB first, cs low, send 0xDEADBEEF, cs high -> out_valid with out_data=0xDEADBEEF, out_first=1.
REQ-031 SHALL cover mode 3, LSBFIRST=1, two words 0x12345678,0x9ABCDEF0 in one cs frame -> popped in order, out_first 1 then 0.
REQ-032 SHALL cover FIFO_DEPTH=4, out_ready=0, five words sent -> level=4, one overflow pulse on the 5th, first four words intact.
REQ-033 SHALL cover cs raised after 13 bits, then a new frame with 0x00000001 -> only 0x00000001 delivered, out_first=1.
REQ-034 SHALL cover full FIFO with out_ready=1 in the push cycle -> word accepted, no overflow, level stays 4.
REQ-035 SHALL cover, with SPI_RX_FIFO_TIMEOUT_EN and TIMEOUT_CYCLES=64, 8 bits then a 100-cycle pause, then 32 bits of 0xA5A5A5A5 -> only 0xA5A5A5A5 delivered.
